// File: rtl/i2c_master_byte_if.sv
// Register-bus interface of the I2C byte master.
//   address      : register offset (0x0 CMD, 0x4 STATUS, 0x8 DIV)
//   data_in      : write data
//   data_write_n : 2'b11 = idle, anything else = write
//   data_read_n  : 2'b11 = idle, anything else = read
//   data_out     : read data, combinational, zero when not reading
//   data_ready   : read data valid, same cycle as the read strobe
//   irq          : level interrupt, done & irq_en
// The peripheral uses the slave modport; the CPU side (or bench) uses master.
interface i2c_master_byte_if;
  logic [3:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        irq;

  modport slave (
    input  address, data_in, data_write_n, data_read_n,
    output data_out, data_ready, irq
  );

  modport master (
    output address, data_in, data_write_n, data_read_n,
    input  data_out, data_ready, irq
  );
endinterface

// File: rtl/i2c_master_byte.sv
// I2C master byte engine on the TinyQV data bus.
// One command does: optional START, one byte WRITE or READ plus its ACK slot,
// optional STOP. Completion raises done and, when enabled, a level irq.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : register interface (slave modport)
//   scl_o      : SCL, 1 = released, 0 = driven low
//   sda_o      : SDA, 1 = released, 0 = driven low
//   sda_i      : SDA bus value (wired-AND of master and slave)
// Every phase is built from quarters of div+1 clocks.
module i2c_master_byte #(
  parameter logic [7:0] DIV_RESET = 8'd62
) (
  input  logic             clk,
  input  logic             rst_n,
  i2c_master_byte_if.slave bus,
  output logic             scl_o,
  output logic             sda_o,
  input  logic             sda_i
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP} state_t;

  state_t     state, state_nxt;
  logic       busy, fin, qend;
  logic       done, rx_nack, irq_en;
  logic       owned, sda_hold, rep;
  logic       c_stop, c_byte, c_wr, c_nack;
  logic [7:0] div, cnt, tx_sh, rx_sh, rx_data;
  logic [1:0] q;
  logic [2:0] bitn;
  logic       wr_en, cmd_acc, stat_wr, div_wr;
  logic       unused_bits;

  assign wr_en   = (bus.data_write_n != 2'b11);
  assign cmd_acc = wr_en && (bus.address == 4'h0) && !busy && (|bus.data_in[3:0]);
  assign stat_wr = wr_en && (bus.address == 4'h4);
  assign div_wr  = wr_en && (bus.address == 4'h8);
  assign busy    = (state != S_IDLE);
  assign qend    = busy && (cnt == 8'd0);
  assign fin     = busy && (state_nxt == S_IDLE);
  assign unused_bits = ^bus.data_in[31:16];

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next state; phases not requested are skipped
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:
        if (cmd_acc) begin
          if (bus.data_in[0])                         state_nxt = S_START;
          else if (bus.data_in[2] || bus.data_in[3])  state_nxt = S_BIT;
          else                                        state_nxt = S_STOP;
        end
      S_START:
        if (qend && q == 2'd2)
          state_nxt = c_byte ? S_BIT : (c_stop ? S_STOP : S_IDLE);
      S_BIT:
        if (qend && q == 2'd3 && bitn == 3'd7) state_nxt = S_ACK;
      S_ACK:
        if (qend && q == 2'd3) state_nxt = c_stop ? S_STOP : S_IDLE;
      S_STOP:
        if (qend && q == 2'd2) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // outputs (SCL, SDA) per phase and quarter
  always_comb begin
    scl_o = 1'b1;
    sda_o = 1'b1;
    case (state)
      S_IDLE:
        // without STOP the bus stays owned: SCL low, SDA frozen
        if (owned) begin
          scl_o = 1'b0;
          sda_o = sda_hold;
        end
      S_START:
        // repeated START shifts the pattern one quarter: release SDA
        // with SCL low first, then SCL high, then SDA falls
        case (q)
          2'd0:    begin scl_o = !rep; sda_o = 1'b1; end
          2'd1:    begin scl_o = 1'b1; sda_o = rep;  end
          default: begin scl_o = rep;  sda_o = 1'b0; end
        endcase
      S_BIT: begin
        scl_o = (q == 2'd1) || (q == 2'd2);
        sda_o = c_wr ? tx_sh[7] : 1'b1;
      end
      S_ACK: begin
        scl_o = (q == 2'd1) || (q == 2'd2);
        sda_o = c_wr ? 1'b1 : c_nack;
      end
      S_STOP:
        case (q)
          2'd0:    begin scl_o = 1'b0; sda_o = 1'b0; end
          2'd1:    begin scl_o = 1'b1; sda_o = 1'b0; end
          default: begin scl_o = 1'b1; sda_o = 1'b1; end
        endcase
      default: ;
    endcase
  end

  // quarter timing, shifters and registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 8'd0;
      q        <= 2'd0;
      bitn     <= 3'd0;
      tx_sh    <= 8'd0;
      rx_sh    <= 8'd0;
      rx_data  <= 8'd0;
      rx_nack  <= 1'b0;
      done     <= 1'b0;
      irq_en   <= 1'b0;
      div      <= DIV_RESET;
      owned    <= 1'b0;
      sda_hold <= 1'b1;
      rep      <= 1'b0;
      c_stop   <= 1'b0;
      c_byte   <= 1'b0;
      c_wr     <= 1'b0;
      c_nack   <= 1'b0;
    end else begin
      if (cmd_acc) begin
        c_stop <= bus.data_in[1];
        c_byte <= bus.data_in[2] | bus.data_in[3];
        c_wr   <= bus.data_in[2];   // WRITE wins over READ
        c_nack <= bus.data_in[4];
        tx_sh  <= bus.data_in[15:8];
        rep    <= owned;
        cnt    <= div;
        q      <= 2'd0;
        bitn   <= 3'd0;
        done   <= 1'b0;
      end else if (busy) begin
        if (qend) begin
          // reload from div here so a DIV write lands on a quarter boundary
          cnt <= div;
          q   <= (state_nxt != state) ? 2'd0 : q + 2'd1;
          if (state == S_BIT) begin
            if (q == 2'd2 && !c_wr) rx_sh <= {rx_sh[6:0], sda_i};
            if (q == 2'd3) begin
              bitn  <= bitn + 3'd1;
              tx_sh <= {tx_sh[6:0], 1'b0};
            end
          end
          if (state == S_ACK && q == 2'd2 && c_wr) rx_nack <= sda_i;
        end else begin
          cnt <= cnt - 8'd1;
        end
      end
      if (stat_wr) begin
        irq_en <= bus.data_in[3];
        if (bus.data_in[2]) done <= 1'b0;
      end
      if (div_wr) div <= bus.data_in[7:0];
      // completion after the clear so a simultaneous event is not lost
      if (fin) begin
        done     <= 1'b1;
        owned    <= (state != S_STOP);
        sda_hold <= sda_o;
        if (c_byte && !c_wr) rx_data <= rx_sh;
      end
    end
  end

  // register reads
  always_comb begin
    bus.data_ready = (bus.data_read_n != 2'b11);
    bus.data_out   = 32'd0;
    if (bus.data_ready) begin
      case (bus.address)
        4'h4:    bus.data_out = {16'd0, rx_data, 4'd0, irq_en, done, rx_nack, busy};
        4'h8:    bus.data_out = {24'd0, div};
        default: bus.data_out = 32'd0;
      endcase
    end
  end

  assign bus.irq = done & irq_en;

endmodule
